// File: rtl/dispensador_billetes.sv
// Cash-dispense stage: plans a greedy, inventory-limited bill breakdown for a requested
// amount and releases the bills one by one to the dispensing mechanism.
module dispensador_billetes #(
    parameter logic [31:0] DEN0  = 32'd20000,
    parameter logic [31:0] DEN1  = 32'd10000,
    parameter logic [31:0] DEN2  = 32'd5000,
    parameter logic [31:0] DEN3  = 32'd1000,
    parameter int unsigned INV_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ENTREGAR_DINERO,
    input  logic [31:0]        MONTO,
    input  logic               BILLETE_ACK,
    input  logic               RECARGA_STB,
    input  logic [1:0]         RECARGA_TIPO,
    input  logic [INV_W-1:0]   RECARGA_CANT,
    output logic               BILLETE_STB,
    output logic [1:0]         BILLETE_TIPO,
    output logic               OCUPADO,
    output logic               FIN_DISPENSA,
    output logic               ERROR_DISPENSA,
    output logic [4*INV_W-1:0] INVENTARIO,
    output logic [2:0]         ESTADO_DBG
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAN     = 3'd1,
        S_CHECK    = 3'd2,
        S_DISPENSE = 3'd3,
        S_FIN      = 3'd4
    } estado_t;

    localparam logic [INV_W-1:0] UNO = INV_W'(1);

    estado_t          estado_q;
    logic [31:0]      resto_q;
    logic [1:0]       idx_q;
    logic [INV_W-1:0] plan_q [4];
    logic [INV_W-1:0] inv_q  [4];
    logic             stb_q;
    logic [1:0]       tipo_q;
    logic             ocupado_q;
    logic             fin_q;
    logic             error_q;

    logic [31:0]      den_d;
    logic             puede_d;
    logic             plan_any_d;
    logic [1:0]       sig_tipo_d;
    logic             ultimo_d;
    logic [INV_W:0]   recarga_sum_d;
    logic [INV_W-1:0] recarga_sat_d;

    always_comb begin
        den_d = DEN0;
        case (idx_q)
            2'd0: den_d = DEN0;
            2'd1: den_d = DEN1;
            2'd2: den_d = DEN2;
            2'd3: den_d = DEN3;
            default: den_d = DEN0;
        endcase
    end

    // One bill per PLAN cycle while it fits and the stock covers it.
    assign puede_d = (resto_q >= den_d) && (plan_q[idx_q] < inv_q[idx_q]);

    always_comb begin
        plan_any_d = 1'b0;
        sig_tipo_d = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (plan_q[i] != '0) begin
                plan_any_d = 1'b1;
                sig_tipo_d = 2'(i);
            end
        end
    end

    // True when acknowledging the bill on display empties the whole plan.
    always_comb begin
        ultimo_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == tipo_q) begin
                if (plan_q[i] != UNO) ultimo_d = 1'b0;
            end else if (plan_q[i] != '0) begin
                ultimo_d = 1'b0;
            end
        end
    end

    assign recarga_sum_d = {1'b0, inv_q[RECARGA_TIPO]} + {1'b0, RECARGA_CANT};
    assign recarga_sat_d = recarga_sum_d[INV_W] ? {INV_W{1'b1}} : recarga_sum_d[INV_W-1:0];

    // Handshake: BILLETE_STB with BILLETE_TIPO is held stable until a cycle with
    // BILLETE_ACK=1; that cycle transfers the bill. ACK while STB=0 has no effect.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            estado_q  <= S_IDLE;
            resto_q   <= '0;
            idx_q     <= '0;
            stb_q     <= 1'b0;
            tipo_q    <= '0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
            error_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                plan_q[i] <= '0;
                inv_q[i]  <= '0;
            end
        end else begin
            fin_q   <= 1'b0;
            error_q <= 1'b0;
            case (estado_q)
                S_IDLE: begin
                    if (ENTREGAR_DINERO) begin
                        resto_q   <= MONTO;
                        idx_q     <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= S_PLAN;
                        for (int i = 0; i < 4; i++) plan_q[i] <= '0;
                    end else if (RECARGA_STB) begin
                        inv_q[RECARGA_TIPO] <= recarga_sat_d;
                    end
                end
                S_PLAN: begin
                    if (puede_d) begin
                        resto_q       <= resto_q - den_d;
                        plan_q[idx_q] <= plan_q[idx_q] + UNO;
                    end else if (idx_q == 2'd3) begin
                        estado_q <= S_CHECK;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                S_CHECK: begin
                    if (resto_q != '0) begin
                        error_q   <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= S_IDLE;
                        for (int i = 0; i < 4; i++) plan_q[i] <= '0;
                    end else if (plan_any_d) begin
                        stb_q    <= 1'b1;
                        tipo_q   <= sig_tipo_d;
                        estado_q <= S_DISPENSE;
                    end else begin
                        fin_q    <= 1'b1;
                        estado_q <= S_FIN;
                    end
                end
                S_DISPENSE: begin
                    if (stb_q) begin
                        if (BILLETE_ACK) begin
                            stb_q          <= 1'b0;
                            plan_q[tipo_q] <= plan_q[tipo_q] - UNO;
                            inv_q[tipo_q]  <= inv_q[tipo_q] - UNO;
                            if (ultimo_d) begin
                                fin_q    <= 1'b1;
                                estado_q <= S_FIN;
                            end
                        end
                    end else begin
                        stb_q  <= 1'b1;
                        tipo_q <= sig_tipo_d;
                    end
                end
                S_FIN: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= S_IDLE;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    stb_q     <= 1'b0;
                    estado_q  <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        INVENTARIO = '0;
        for (int i = 0; i < 4; i++) INVENTARIO[i*INV_W +: INV_W] = inv_q[i];
    end

    assign BILLETE_STB    = stb_q;
    assign BILLETE_TIPO   = tipo_q;
    assign OCUPADO        = ocupado_q;
    assign FIN_DISPENSA   = fin_q;
    assign ERROR_DISPENSA = error_q;
    assign ESTADO_DBG     = estado_q;

endmodule

// File: tb/tb_dispensador_billetes.sv
// Directed bench for dispensador_billetes: dispense sequences, inventory bookkeeping,
// error timing, handshake hold, refill saturation and asynchronous reset.
module tb_dispensador_billetes;

  logic        clk;
  logic        rst;
  logic        entregar;
  logic [31:0] monto;
  logic        ack;
  logic        rec_stb;
  logic [1:0]  rec_tipo;
  logic [7:0]  rec_cant;
  logic        stb;
  logic [1:0]  tipo;
  logic        ocupado;
  logic        fin;
  logic        err;
  logic [31:0] inventario;
  logic [2:0]  estado;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  dispensador_billetes dut (
    .Clk            (clk),
    .Reset          (rst),
    .ENTREGAR_DINERO(entregar),
    .MONTO          (monto),
    .BILLETE_ACK    (ack),
    .RECARGA_STB    (rec_stb),
    .RECARGA_TIPO   (rec_tipo),
    .RECARGA_CANT   (rec_cant),
    .BILLETE_STB    (stb),
    .BILLETE_TIPO   (tipo),
    .OCUPADO        (ocupado),
    .FIN_DISPENSA   (fin),
    .ERROR_DISPENSA (err),
    .INVENTARIO     (inventario),
    .ESTADO_DBG     (estado)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // driver tasks
  task automatic do_refill(input logic [1:0] t, input logic [7:0] n);
    rec_stb  = 1'b1;
    rec_tipo = t;
    rec_cant = n;
    tick();
    rec_stb  = 1'b0;
  endtask

  task automatic do_request(input logic [31:0] m);
    entregar = 1'b1;
    monto    = m;
    tick();
    entregar = 1'b0;
  endtask

  // Acknowledges each presented bill ack_delay cycles after it appears, logging types.
  task automatic run_dispense(input int ack_delay, output int fin_cnt);
    int wait_c;
    fin_cnt = 0;
    wait_c  = 0;
    for (int g = 0; g < 400; g++) begin
      if (fin) fin_cnt++;
      if (fin_cnt > 0 && !ocupado) break;
      if (stb && !ack) begin
        if (wait_c == ack_delay) begin
          ack = 1'b1;
          got_q.push_back(tipo);
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end else begin
        ack = 1'b0;
      end
      tick();
    end
    ack = 1'b0;
  endtask

  // scoreboard comparison of delivered bill types
  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_bill%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int fin_cnt;
    int err_first;
    int err_cnt;
    int stb_seen;
    int stable;
    int acks;
    int pulses;

    rst = 1'b1; entregar = 1'b0; monto = '0; ack = 1'b0;
    rec_stb = 1'b0; rec_tipo = '0; rec_cant = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_fin", 32'(fin), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_inv", inventario, 32'd0);
    chk("rst_estado", 32'(estado), 32'd0);

    // 1: 10 of each, 37000 -> 0,1,2,3,3
    for (int t = 0; t < 4; t++) do_refill(2'(t), 8'd10);
    chk("t1_inv_refill", inventario, pack(8'd10, 8'd10, 8'd10, 8'd10));
    do_request(32'd37000);
    chk("t1_ocupado", 32'(ocupado), 32'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd3);
    run_dispense(2, fin_cnt);
    chk("t1_fin", 32'(fin_cnt), 32'd1);
    chk_seq("t1_seq");
    chk("t1_inv", inventario, pack(8'd9, 8'd9, 8'd9, 8'd8));

    // 2: inventory {0,5,5,5}, 37000 -> 1,1,1,2,3,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 1; t < 4; t++) do_refill(2'(t), 8'd5);
    chk("t2_inv_refill", inventario, pack(8'd0, 8'd5, 8'd5, 8'd5));
    do_request(32'd37000);
    exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd3);
    run_dispense(2, fin_cnt);
    chk("t2_fin", 32'(fin_cnt), 32'd1);
    chk_seq("t2_seq");
    chk("t2_inv", inventario, pack(8'd0, 8'd2, 8'd4, 8'd3));

    // 3: 1500 is not payable; error pulse on the 7th cycle counting the request cycle
    do_request(32'd1500);
    err_first = -1; err_cnt = 0; stb_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (err) begin
        err_cnt++;
        if (err_first < 0) err_first = k;
      end
      if (stb) stb_seen++;
    end
    chk("t3_err_cycle", 32'(err_first), 32'd6);
    chk("t3_err_pulses", 32'(err_cnt), 32'd1);
    chk("t3_no_stb", 32'(stb_seen), 32'd0);
    chk("t3_ocupado", 32'(ocupado), 32'd0);
    chk("t3_inv", inventario, pack(8'd0, 8'd2, 8'd4, 8'd3));

    do_request(32'd0);
    run_dispense(0, fin_cnt);
    chk("t3_zero_fin", 32'(fin_cnt), 32'd1);
    chk_seq("t3_zero_seq");
    chk("t3_zero_inv", inventario, pack(8'd0, 8'd2, 8'd4, 8'd3));

    // 4: hold ACK low 20 cycles; pulses while busy are ignored
    do_refill(2'd0, 8'd10);
    do_request(32'd25000);
    for (int g = 0; g < 40 && !stb; g++) tick();
    chk("t4_stb_up", 32'(stb), 32'd1);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      if (!(stb === 1'b1 && tipo === 2'd0 && inventario === pack(8'd10, 8'd2, 8'd4, 8'd3)))
        stable = 0;
      entregar = (c == 5);
      monto    = 32'd20000;
      rec_stb  = (c == 7);
      rec_tipo = 2'd1;
      rec_cant = 8'd7;
      tick();
    end
    entregar = 1'b0;
    rec_stb  = 1'b0;
    chk("t4_stable", 32'(stable), 32'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    run_dispense(0, fin_cnt);
    chk("t4_fin", 32'(fin_cnt), 32'd1);
    chk_seq("t4_seq");
    chk("t4_inv", inventario, pack(8'd9, 8'd2, 8'd3, 8'd3));
    tick(); tick(); tick();
    chk("t4_idle_after", 32'(ocupado), 32'd0);

    // 5: refill saturation, request beats refill
    do_refill(2'd2, 8'd250);
    chk("t5_inv_253", inventario, pack(8'd9, 8'd2, 8'd253, 8'd3));
    do_refill(2'd2, 8'd10);
    chk("t5_inv_sat", inventario, pack(8'd9, 8'd2, 8'd255, 8'd3));
    entregar = 1'b1; monto = 32'd0;
    rec_stb = 1'b1; rec_tipo = 2'd3; rec_cant = 8'd5;
    tick();
    entregar = 1'b0; rec_stb = 1'b0;
    run_dispense(0, fin_cnt);
    chk("t5_fin", 32'(fin_cnt), 32'd1);
    chk("t5_inv_dropped", inventario, pack(8'd9, 8'd2, 8'd255, 8'd3));

    // 6: asynchronous reset after the second ACK of a 5-bill dispense
    do_request(32'd37000);
    acks = 0;
    for (int g = 0; g < 100 && acks < 2; g++) begin
      if (stb && !ack) begin
        ack = 1'b1;
        acks++;
      end else begin
        ack = 1'b0;
      end
      tick();
    end
    ack = 1'b0;
    chk("t6_acks", 32'(acks), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_stb", 32'(stb), 32'd0);
    chk("t6_rst_tipo", 32'(tipo), 32'd0);
    chk("t6_rst_ocupado", 32'(ocupado), 32'd0);
    chk("t6_rst_inv", inventario, 32'd0);
    chk("t6_rst_estado", 32'(estado), 32'd0);
    #1 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (fin || err || stb) pulses++;
    end
    chk("t6_no_pulses", 32'(pulses), 32'd0);
    for (int t = 0; t < 4; t++) do_refill(2'(t), 8'd10);
    do_request(32'd37000);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd3);
    run_dispense(2, fin_cnt);
    chk("t6_fin", 32'(fin_cnt), 32'd1);
    chk_seq("t6_seq");
    chk("t6_inv", inventario, pack(8'd9, 8'd9, 8'd9, 8'd8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
